// File: rtl/id_sb_pkg.sv
// -----------------------------------------------------------------------------
// id_sb_pkg
// Shared definitions for the decode/issue stage with per-register scoreboard.
//   SB_XLEN / SB_NREG / SB_RIDX : default datapath width, register count and
//                                 register index width.
//   cnt_width()                 : width of a counter able to hold 0..max.
//   issue_t                     : payload held in the issue output register.
// No ports (package).
// -----------------------------------------------------------------------------
package id_sb_pkg;

    localparam int SB_XLEN = 32;
    localparam int SB_NREG = 32;
    localparam int SB_RIDX = $clog2(SB_NREG);

    function automatic int cnt_width(input int max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    // Sized from the package defaults; the issue stage is built with the same
    // XLEN/NREG.
    typedef struct packed {
        logic [SB_XLEN-1:0] pc4;
        logic [SB_RIDX-1:0] rd;
        logic               wreg;
        logic [SB_XLEN-1:0] a;
        logic [SB_XLEN-1:0] b;
    } issue_t;

endpackage

// File: rtl/id_sb_regfile.sv
// -----------------------------------------------------------------------------
// id_sb_regfile
// NREG x XLEN register file, two combinational read ports, one write port.
// Register 0 always reads as zero. A read of the index being written in the
// same cycle returns the write data (write-through bypass).
// Ports:
//   clk, clrn      : clock, asynchronous active-high reset (clears storage)
//   we, wa, wd     : write enable, write index, write data
//   ra1/rd1        : read port 1 index / data
//   ra2/rd2        : read port 2 index / data
// -----------------------------------------------------------------------------
module id_sb_regfile
    import id_sb_pkg::*;
#(
    parameter int XLEN = SB_XLEN,
    parameter int NREG = SB_NREG,
    parameter int RIDX = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            we,
    input  logic [RIDX-1:0] wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RIDX-1:0] ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [RIDX-1:0] ra2,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != '0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets a consumer see a value retiring in the same cycle.
    always_comb begin
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[ra1];
        end

        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

endmodule

// File: rtl/id_sb_issue.sv
// -----------------------------------------------------------------------------
// id_sb_issue
// Decode/issue stage: per-register scoreboard of outstanding writers, an
// integrated register file with write-through bypass, and a one-entry
// valid/ready output register feeding EXE, flushable on taken branch/jump.
//
// Optional macro SB_BYPASS_EN: when defined, a source whose only outstanding
// writer releases and writes back in this same cycle is not treated as busy,
// so the reader issues immediately and picks up wb_data through the bypass.
// Without it the reader waits one more cycle for the counter to reach zero.
//
// Ports:
//   clk, clrn                    : clock, asynchronous active-high reset
//   in_valid / in_ready          : decoded-instruction handshake
//   in_pc4, in_rs, in_rt, in_rd  : PC+4 and register indices
//   in_uses_rs, in_uses_rt       : instruction reads rs / rt
//   in_wreg                      : instruction writes in_rd
//   out_valid / out_ready        : handshake toward EXE
//   out_a, out_b, out_rd,
//   out_wreg, out_pc4            : held issue payload
//   flush                        : discard the held entry
//   wb_we, wb_rd, wb_data        : register file writeback
//   rel_valid, rel_rd            : writer retired or squashed downstream
//   sb_err                       : sticky scoreboard underflow flag
// -----------------------------------------------------------------------------
module id_sb_issue
    import id_sb_pkg::*;
#(
    parameter int XLEN         = SB_XLEN,
    parameter int NREG         = SB_NREG,
    parameter int RIDX         = $clog2(NREG),
    parameter int MAX_INFLIGHT = 4,
    parameter int CW           = cnt_width(MAX_INFLIGHT)
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [RIDX-1:0] in_rs,
    input  logic [RIDX-1:0] in_rt,
    input  logic [RIDX-1:0] in_rd,
    input  logic            in_uses_rs,
    input  logic            in_uses_rt,
    input  logic            in_wreg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [RIDX-1:0] out_rd,
    output logic            out_wreg,
    output logic [XLEN-1:0] out_pc4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rel_valid,
    input  logic [RIDX-1:0] rel_rd,
    output logic            sb_err
);

    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            sb_err_q;
    logic            sb_err_d;
    logic            out_valid_q;
    logic            out_valid_d;
    issue_t          out_q;
    issue_t          out_d;

    logic            busy_rs;
    logic            busy_rt;
    logic            hazard_rs;
    logic            hazard_rt;
    logic            full_rd;
    logic            fire;
    logic            undo_flush;
    logic            inc_hit;
    logic            rel_hit;
    logic            undo_hit;
    logic [CW+1:0]   sum_w;
    logic [CW+1:0]   dec_w;

    id_sb_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RIDX (RIDX)
    ) u_regfile (
        .clk  (clk),
        .clrn (clrn),
        .we   (wb_we),
        .wa   (wb_rd),
        .wd   (wb_data),
        .ra1  (in_rs),
        .rd1  (rs_val),
        .ra2  (in_rt),
        .rd2  (rt_val)
    );

    always_comb begin
        busy_rs = (cnt_q[in_rs] != '0);
        busy_rt = (cnt_q[in_rt] != '0);
`ifdef SB_BYPASS_EN
        // Last writer retiring with its data right now: value comes via bypass.
        if ((cnt_q[in_rs] == CW'(1)) && rel_valid && (rel_rd == in_rs) &&
            wb_we && (wb_rd == in_rs)) begin
            busy_rs = 1'b0;
        end
        if ((cnt_q[in_rt] == CW'(1)) && rel_valid && (rel_rd == in_rt) &&
            wb_we && (wb_rd == in_rt)) begin
            busy_rt = 1'b0;
        end
`endif
        hazard_rs  = in_uses_rs && (in_rs != '0) && busy_rs;
        hazard_rt  = in_uses_rt && (in_rt != '0) && busy_rt;
        full_rd    = in_wreg && (in_rd != '0) && (cnt_q[in_rd] == CW'(MAX_INFLIGHT));
        in_ready   = !flush && (!out_valid_q || out_ready) &&
                     !hazard_rs && !hazard_rt && !full_rd;
        fire       = in_valid && in_ready;
        undo_flush = flush && out_valid_q && out_q.wreg && (out_q.rd != '0);
    end

    // Each counter nets its increment against both decrement sources. A
    // release at zero is dropped and flagged; any other attempt to go below
    // zero is clamped and flagged as well.
    always_comb begin
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        inc_hit  = 1'b0;
        rel_hit  = 1'b0;
        undo_hit = 1'b0;
        sum_w    = '0;
        dec_w    = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_hit  = fire && in_wreg && (in_rd == RIDX'(i));
            rel_hit  = rel_valid && (rel_rd == RIDX'(i));
            undo_hit = undo_flush && (out_q.rd == RIDX'(i));
            if (rel_hit && (cnt_q[i] == '0)) begin
                sb_err_d = 1'b1;
                rel_hit  = 1'b0;
            end
            sum_w = (CW+2)'(cnt_q[i]) + (CW+2)'(inc_hit);
            dec_w = (CW+2)'(rel_hit) + (CW+2)'(undo_hit);
            if (dec_w > sum_w) begin
                cnt_d[i] = '0;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[i] = CW'(sum_w - dec_w);
            end
        end
    end

    // Flush already blocks fire through in_ready, so it only needs to drop
    // the held entry.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_d.pc4   = in_pc4;
            out_d.rd    = in_rd;
            out_d.wreg  = in_wreg;
            out_d.a     = rs_val;
            out_d.b     = rt_val;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            cnt_q       <= '{default: '0};
            sb_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sb_err_q    <= sb_err_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_q.a;
    assign out_b     = out_q.b;
    assign out_rd    = out_q.rd;
    assign out_wreg  = out_q.wreg;
    assign out_pc4   = out_q.pc4;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_id_sb_issue.sv
// -----------------------------------------------------------------------------
// tb_id_sb_issue
// Self-checking bench for id_sb_issue: directed scenarios plus a randomized
// run compared against a behavioural model of the issue stage (outstanding
// writer counts, register values and the held output entry).
// Honours SB_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_id_sb_issue;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RIDX = 5;
    localparam int MAXI = 4;

    logic            clk = 1'b0;
    logic            clrn;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc4;
    logic [RIDX-1:0] in_rs;
    logic [RIDX-1:0] in_rt;
    logic [RIDX-1:0] in_rd;
    logic            in_uses_rs;
    logic            in_uses_rt;
    logic            in_wreg;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [RIDX-1:0] out_rd;
    logic            out_wreg;
    logic [XLEN-1:0] out_pc4;
    logic            flush;
    logic            wb_we;
    logic [RIDX-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            rel_valid;
    logic [RIDX-1:0] rel_rd;
    logic            sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int              m_cnt  [NREG];
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_valid;
    logic            m_wreg;
    logic [RIDX-1:0] m_rd;
    logic [XLEN-1:0] m_a;
    logic [XLEN-1:0] m_b;
    logic [XLEN-1:0] m_pc4;
    logic            m_err;

    always #5 clk = ~clk;

    id_sb_issue dut (
        .clk        (clk),
        .clrn       (clrn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc4     (in_pc4),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_uses_rs (in_uses_rs),
        .in_uses_rt (in_uses_rt),
        .in_wreg    (in_wreg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .out_wreg   (out_wreg),
        .out_pc4    (out_pc4),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rel_valid  (rel_valid),
        .rel_rd     (rel_rd),
        .sb_err     (sb_err)
    );

    function automatic logic m_busy(input logic [RIDX-1:0] r);
        logic retiring = 1'b0;
`ifdef SB_BYPASS_EN
        retiring = (m_cnt[r] == 1) && rel_valid && (rel_rd == r) && wb_we && (wb_rd == r);
`endif
        return (m_cnt[r] != 0) && !retiring;
    endfunction

    function automatic logic m_ready();
        if (flush) return 1'b0;
        if (m_valid && !out_ready) return 1'b0;
        if (in_uses_rs && (in_rs != '0) && m_busy(in_rs)) return 1'b0;
        if (in_uses_rt && (in_rt != '0) && m_busy(in_rt)) return 1'b0;
        if (in_wreg && (in_rd != '0) && (m_cnt[in_rd] >= MAXI)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [RIDX-1:0] r);
        if (r == '0) return '0;
        if (wb_we && (wb_rd == r)) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_cnt[i]  = 0;
            m_regs[i] = '0;
        end
        m_valid = 1'b0;
        m_wreg  = 1'b0;
        m_rd    = '0;
        m_a     = '0;
        m_b     = '0;
        m_pc4   = '0;
        m_err   = 1'b0;
    endtask

    task automatic set_idle();
        in_valid   = 1'b0;
        in_pc4     = '0;
        in_rs      = '0;
        in_rt      = '0;
        in_rd      = '0;
        in_uses_rs = 1'b0;
        in_uses_rt = 1'b0;
        in_wreg    = 1'b0;
        out_ready  = 1'b1;
        flush      = 1'b0;
        wb_we      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        rel_valid  = 1'b0;
        rel_rd     = '0;
    endtask

    // One clock edge; the model advances with the inputs applied this cycle.
    task automatic tick();
        logic            f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        f = in_valid && m_ready();
        a = m_read(in_rs);
        b = m_read(in_rt);
        @(posedge clk);
        if (rel_valid && (rel_rd != '0)) begin
            if (m_cnt[rel_rd] == 0) m_err = 1'b1;
            else m_cnt[rel_rd] = m_cnt[rel_rd] - 1;
        end
        if (flush && m_valid && m_wreg && (m_rd != '0)) begin
            if (m_cnt[m_rd] == 0) m_err = 1'b1;
            else m_cnt[m_rd] = m_cnt[m_rd] - 1;
        end
        if (f && in_wreg && (in_rd != '0)) m_cnt[in_rd] = m_cnt[in_rd] + 1;
        if (wb_we && (wb_rd != '0)) m_regs[wb_rd] = wb_data;
        if (f) begin
            m_valid = 1'b1;
            m_a     = a;
            m_b     = b;
            m_rd    = in_rd;
            m_wreg  = in_wreg;
            m_pc4   = in_pc4;
        end else if (flush || out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        clrn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        clrn = 1'b1;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_a !== '0) begin n_fail++; $display("[TB] FAIL reset_out_a: got %h expected 0", out_a); end
        n_checks++; if (out_b !== '0) begin n_fail++; $display("[TB] FAIL reset_out_b: got %h expected 0", out_b); end
        n_checks++; if (out_rd !== '0) begin n_fail++; $display("[TB] FAIL reset_out_rd: got %h expected 0", out_rd); end
        n_checks++; if (out_wreg !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_wreg: got %b expected 0", out_wreg); end
        n_checks++; if (out_pc4 !== '0) begin n_fail++; $display("[TB] FAIL reset_out_pc4: got %h expected 0", out_pc4); end
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sb_err: got %b expected 0", sb_err); end
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_issue();
        set_idle();
        in_valid = 1'b1; in_rd = 5'd5; in_wreg = 1'b1; in_pc4 = 32'h100;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL issue_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL issue_out_valid: got %b expected 1", out_valid); end
        n_checks++; if ({out_rd, out_wreg, out_pc4} !== {5'd5, 1'b1, 32'h100}) begin n_fail++; $display("[TB] FAIL issue_payload: got rd=%0d wreg=%b pc4=%h expected rd=5 wreg=1 pc4=100", out_rd, out_wreg, out_pc4); end
        in_rd = '0; in_wreg = 1'b0; in_rs = 5'd5; in_uses_rs = 1'b1; in_pc4 = 32'h104;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall: got %b expected 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_out_valid: got %b expected 0", out_valid); end
        set_idle();
    endtask

    task automatic test_bypass();
        set_idle();
        in_valid = 1'b1; in_uses_rs = 1'b1; in_rs = 5'd5; in_pc4 = 32'h200;
        rel_valid = 1'b1; rel_rd = 5'd5;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef SB_BYPASS_EN
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_ready: got %b expected 1", in_ready); end
        tick();
`else
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_stall: got %b expected 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_no_issue: got %b expected 0", out_valid); end
        rel_valid = 1'b0; wb_we = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_late_ready: got %b expected 1", in_ready); end
        tick();
`endif
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_a !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL bypass_out_a: got %h expected deadbeef", out_a); end
        set_idle();
        tick();
    endtask

    task automatic test_full();
        set_idle();
        in_valid = 1'b1; in_wreg = 1'b1; in_rd = 5'd7;
        for (int k = 0; k < 4; k++) begin
            in_pc4 = 32'h700 + 32'(4 * k);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_issue%0d: got %b expected 1", k, in_ready); end
            tick();
        end
        in_pc4 = 32'h710;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_block: got %b expected 0", in_ready); end
        tick();
        rel_valid = 1'b1; rel_rd = 5'd7;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_block_rel: got %b expected 0", in_ready); end
        tick();
        rel_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_after_rel: got %b expected 1", in_ready); end
        tick();
        n_checks++; if ({out_valid, out_pc4} !== {1'b1, 32'h710}) begin n_fail++; $display("[TB] FAIL full_fifth_out: got v=%b pc4=%h expected v=1 pc4=710", out_valid, out_pc4); end
        set_idle();
        rel_valid = 1'b1; rel_rd = 5'd7;
        repeat (4) tick();
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        out_ready = 1'b0;
        in_valid = 1'b1; in_rd = 5'd3; in_wreg = 1'b1; in_pc4 = 32'h300;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_held: got %b expected 1", out_valid); end
        in_rd = 5'd4; in_pc4 = 32'h304;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_backpressure: got %b expected 0", in_ready); end
        tick();
        n_checks++; if ({out_valid, out_rd, out_pc4} !== {1'b1, 5'd3, 32'h300}) begin n_fail++; $display("[TB] FAIL flush_stable: got v=%b rd=%0d pc4=%h expected v=1 rd=3 pc4=300", out_valid, out_rd, out_pc4); end
        flush = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
        flush = 1'b0;
        in_wreg = 1'b0; in_rd = '0; in_uses_rs = 1'b1; in_rs = 5'd3; in_pc4 = 32'h308;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_undo: got %b expected 1", in_ready); end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_sb_err();
        set_idle();
        rel_valid = 1'b1; rel_rd = 5'd9;
        tick();
        rel_valid = 1'b0;
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL sberr_set: got %b expected 1", sb_err); end
        tick();
        tick();
        n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL sberr_sticky: got %b expected 1", sb_err); end
        in_valid = 1'b1; in_uses_rs = 1'b1; in_rs = 5'd9;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sberr_cnt_zero: got %b expected 1", in_ready); end
        tick();
        set_idle();
        tick();
        apply_reset();
        n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("[TB] FAIL sberr_reset: got %b expected 0", sb_err); end
    endtask

    task automatic test_zero_reg();
        set_idle();
        wb_we = 1'b1; wb_rd = '0; wb_data = 32'h1234;
        in_valid = 1'b1; in_uses_rs = 1'b1; in_uses_rt = 1'b1;
        in_rs = '0; in_rt = '0; in_rd = '0; in_wreg = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_pc4 = 32'(4 * k);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ready%0d: got %b expected 1", k, in_ready); end
            tick();
            n_checks++; if ({out_valid, out_a, out_b} !== {1'b1, 32'h0, 32'h0}) begin n_fail++; $display("[TB] FAIL zero_read%0d: got v=%b a=%h b=%h expected v=1 a=0 b=0", k, out_valid, out_a, out_b); end
        end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        logic [RIDX-1:0] r;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_rs      = RIDX'($urandom_range(0, 7));
            in_rt      = RIDX'($urandom_range(0, 7));
            in_rd      = RIDX'($urandom_range(0, 7));
            in_uses_rs = 1'($urandom_range(0, 1));
            in_uses_rt = 1'($urandom_range(0, 1));
            in_wreg    = 1'($urandom_range(0, 1));
            in_pc4     = $urandom;
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 15) == 0);
            wb_we      = 1'($urandom_range(0, 1));
            wb_rd      = RIDX'($urandom_range(0, 7));
            wb_data    = $urandom;
            r          = RIDX'($urandom_range(1, 7));
            rel_valid  = (m_cnt[r] > 0) && ($urandom_range(0, 1) == 1);
            rel_rd     = r;
            if (flush && m_valid && m_wreg && (m_rd == r)) rel_valid = 1'b0;
            if (rel_valid && ($urandom_range(0, 1) == 1)) begin
                wb_we = 1'b1;
                wb_rd = r;
            end
            #1;
            n_checks++; if (in_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", n, in_ready, m_ready()); end
            tick();
            n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if ({out_a, out_b, out_rd, out_wreg, out_pc4} !== {m_a, m_b, m_rd, m_wreg, m_pc4}) begin n_fail++; $display("[TB] FAIL rnd_payload[%0d]: got a=%h b=%h rd=%0d w=%b pc4=%h expected a=%h b=%h rd=%0d w=%b pc4=%h", n, out_a, out_b, out_rd, out_wreg, out_pc4, m_a, m_b, m_rd, m_wreg, m_pc4); end
            end
            n_checks++; if (sb_err !== m_err) begin n_fail++; $display("[TB] FAIL rnd_sb_err[%0d]: got %b expected %b", n, sb_err, m_err); end
        end
        set_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_issue();
        test_bypass();
        test_full();
        test_flush();
        test_sb_err();
        test_zero_reg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_sb_issue.md
Name: id_sb_issue

Overview:
- Next-generation instruction-decode issue stage for the 5-stage pipeline. Replaces fixed forwarding-select and stall logic with a parametrised per-register scoreboard.
- Contains an integrated register file with write-through bypass.
- Holds one decoded instruction in a valid/ready output register that feeds EXE. Supports flush of the held entry on a taken branch or jump.

Parameters:
- XLEN, 32, datapath width in bits.
- NREG, 32, number of architectural registers; register 0 reads as zero.
- RIDX, $clog2(NREG), register index width.
- MAX_INFLIGHT, 4, maximum outstanding writers per destination register.
- CW, $clog2(MAX_INFLIGHT+1), scoreboard counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous, active-high reset; asserted clears all state.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc4  in  XLEN  PC+4 of the instruction.
- in_rs, in_rt, in_rd  in  RIDX  source and destination indices.
- in_uses_rs, in_uses_rt  in  1  instruction reads rs / rt.
- in_wreg  in  1  instruction writes in_rd.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  EXE accepts.
- out_a, out_b  out  XLEN  operand values.
- out_rd  out  RIDX  destination index.
- out_wreg  out  1  destination write enable.
- out_pc4  out  XLEN  PC+4 carried forward.
- flush  in  1  discard the held output entry.
- wb_we  in  1  writeback data valid.
- wb_rd  in  RIDX  writeback index.
- wb_data  in  XLEN  writeback value.
- rel_valid  in  1  writer retired or squashed downstream.
- rel_rd  in  RIDX  index released.
- sb_err  out  1  sticky scoreboard underflow flag.

Behaviour:
- Reset:
  - All counters are 0.
  - All registers are 0.
  - out_valid, out_a, out_b, out_rd, out_wreg, out_pc4 and sb_err are all 0.
- Register file:
  - Written on the rising edge when wb_we && wb_rd!=0.
  - Read is combinational.
  - Write-through bypass: if wb_we && wb_rd==index && index!=0, the read returns wb_data.
- Scoreboard: one CW-bit counter per register. Counter 0 is never incremented.
- hazard_rs = in_uses_rs && in_rs!=0 && busy(in_rs), where busy(r) = cnt[r]!=0. hazard_rt is defined the same way.
- full_rd = in_wreg && in_rd!=0 && cnt[in_rd]==MAX_INFLIGHT.
- in_ready = !flush && (!out_valid || out_ready) && !hazard_rs && !hazard_rt && !full_rd.
- fire = in_valid && in_ready. On fire:
  - The output register loads the operands, rd, wreg and pc4.
  - out_valid becomes 1.
  - If in_wreg && in_rd!=0, cnt[in_rd] is incremented.
- Output register:
  - When out_valid && out_ready && !fire, out_valid goes to 0.
  - Held data stays stable while out_valid && !out_ready.
- Release: when rel_valid && rel_rd!=0, cnt[rel_rd] is decremented.
  - A release with the counter at 0 is ignored and sets sb_err, which stays set until reset.
- Simultaneous increment and decrement on the same index leave the counter unchanged. This applies to the issue increment, the release decrement and the flush undo.
- Flush:
  - Flush wins over out_ready.
  - out_valid goes to 0 on the next edge and no issue occurs that cycle.
  - If the held entry had out_wreg && out_rd!=0, its count is undone (decremented).
  - Flush with out_valid==0 has no effect.
- Latency: one cycle from fire to out_valid.
- Throughput: one instruction per cycle when no hazards are present.
- Reset asserted mid-operation: all pending counts are lost. Downstream is flushed by the same reset.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined:
  - busy(r) = cnt[r]!=0 && !(cnt[r]==1 && rel_valid && rel_rd==r && wb_we && wb_rd==r).
  - An instruction whose last writer retires this cycle issues in the same cycle and reads wb_data via the bypass.
- Undefined: the instruction stalls one extra cycle until the counter reaches 0.

Decomposition:
- Package id_sb_pkg holds:
  - XLEN and NREG defaults.
  - The counter-width function.
  - A struct for the issue payload (pc4, rd, wreg, a, b).
- Sub-module id_sb_regfile: NREG x XLEN storage, two read ports, one write port, zero register, write-through bypass.

Test Plan:
1. Reset, then issue rd=5 wreg=1 with out_ready=1 -> out_valid=1 after 1 cycle; cnt[5]=1; following reader of rs=5 sees in_ready=0.
2. With cnt[5]=1, assert rel_valid rel_rd=5 together with wb_we wb_rd=5 wb_data=0xDEAD_BEEF while a reader of r5 waits:
   - SB_BYPASS_EN defined -> issues the same cycle with out_a=0xDEADBEEF.
   - SB_BYPASS_EN undefined -> issues one cycle later with the same value.
3. Issue four writers to r7 with no release -> fifth writer to r7 sees in_ready=0; one release -> it issues next cycle.
4. Hold out_ready=0 with an entry rd=3 wreg=1 held, then assert flush -> out_valid=0 next cycle; cnt[3] returns to 0; no transfer downstream.
5. rel_valid rel_rd=9 with cnt[9]=0 -> sb_err=1 and stays 1; counter stays 0. Reset clears sb_err.
6. Read rs=0 while wb_we wb_rd=0 wb_data=0x1234 -> out_a=0; rd=0 writer never blocks or increments.
